// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath
// strobes and ALUop, and traps illegal opcodes and memory timeouts in a sticky ERROR state.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] function_code,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] ALUop,
  output logic [2:0] state,
  output logic       error,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_src_jr,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       byte_en,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_imm,
  output logic       instr_done
);

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_ERROR  = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    CLS_NONE    = 4'd0,
    CLS_RTYPE   = 4'd1,
    CLS_JR      = 4'd2,
    CLS_ADDI    = 4'd3,
    CLS_SUBI    = 4'd4,
    CLS_SLTI    = 4'd5,
    CLS_ANDI    = 4'd6,
    CLS_ORI     = 4'd7,
    CLS_LOAD    = 4'd8,
    CLS_STORE   = 4'd9,
    CLS_BEQ     = 4'd10,
    CLS_BNE     = 4'd11,
    CLS_ILLEGAL = 4'd12
  } cls_t;

  state_t          state_r, state_next_s;
  cls_t            cls_r, dec_cls_s;
  logic            byte_r, dec_byte_s;
  logic [CW-1:0]   wait_cnt_r;
  logic            timeout_s;
  logic [2:0]      alu_op_s;
  logic            pc_write_s, pc_write_cond_s, pc_src_jr_s, ir_write_s;
  logic            mem_read_s, mem_write_s, byte_en_s, reg_write_s;
  logic            reg_dst_s, mem_to_reg_s, alu_src_imm_s, instr_done_s;

  function automatic logic [2:0] class_aluop(input cls_t c);
    case (c)
      CLS_RTYPE, CLS_JR:           class_aluop = 3'b111;
      CLS_SUBI, CLS_BEQ, CLS_BNE:  class_aluop = 3'b110;
      CLS_SLTI:                    class_aluop = 3'b100;
      CLS_ORI:                     class_aluop = 3'b001;
      CLS_ANDI:                    class_aluop = 3'b000;
      default:                     class_aluop = 3'b101;
    endcase
  endfunction

  // Classify the instruction currently presented by the instruction register.
  always_comb begin
    dec_cls_s  = CLS_ILLEGAL;
    dec_byte_s = 1'b0;
    case (opcode)
      6'b000000: dec_cls_s = (function_code == 6'b001000) ? CLS_JR : CLS_RTYPE;
      6'b001000: dec_cls_s = CLS_ADDI;
      6'b001001: dec_cls_s = CLS_SUBI;
      6'b001010: dec_cls_s = CLS_SLTI;
      6'b001100: dec_cls_s = CLS_ANDI;
      6'b001101: dec_cls_s = CLS_ORI;
      6'b100011: dec_cls_s = CLS_LOAD;
      6'b100000: begin
        dec_cls_s  = CLS_LOAD;
        dec_byte_s = 1'b1;
      end
      6'b101011: dec_cls_s = CLS_STORE;
      6'b101000: begin
        dec_cls_s  = CLS_STORE;
        dec_byte_s = 1'b1;
      end
      6'b000100: dec_cls_s = CLS_BEQ;
      6'b000101: dec_cls_s = CLS_BNE;
      default:   dec_cls_s = CLS_ILLEGAL;
    endcase
  end

  // Mem_ready is still accepted on the last counted cycle; only a miss there times out.
  assign timeout_s = (wait_cnt_r == CW'(MEM_TIMEOUT - 1)) && !mem_ready;

  // State register, memory wait counter and instruction-class latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_FETCH;
      wait_cnt_r <= '0;
      cls_r      <= CLS_NONE;
      byte_r     <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (state_next_s != state_r) begin
        wait_cnt_r <= '0;
      end else if ((state_r == ST_FETCH || state_r == ST_MEM) && !mem_ready) begin
        wait_cnt_r <= wait_cnt_r + CW'(1);
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
      if (state_r == ST_DECODE) begin
        cls_r  <= dec_cls_s;
        byte_r <= dec_byte_s;
      end else begin
        cls_r  <= cls_r;
        byte_r <= byte_r;
      end
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_next_s    = state_r;
    alu_op_s        = 3'b101;
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    pc_src_jr_s     = 1'b0;
    ir_write_s      = 1'b0;
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    byte_en_s       = 1'b0;
    reg_write_s     = 1'b0;
    reg_dst_s       = 1'b0;
    mem_to_reg_s    = 1'b0;
    alu_src_imm_s   = 1'b0;
    instr_done_s    = 1'b0;
    case (state_r)
      ST_FETCH: begin
        mem_read_s = 1'b1;
        if (mem_ready) begin
          ir_write_s   = 1'b1;
          pc_write_s   = 1'b1;
          state_next_s = ST_DECODE;
        end else if (timeout_s) begin
          state_next_s = ST_ERROR;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (dec_cls_s == CLS_ILLEGAL) begin
          state_next_s = ST_ERROR;
        end else begin
          state_next_s = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_op_s = class_aluop(cls_r);
        case (cls_r)
          CLS_JR: begin
            pc_write_s   = 1'b1;
            pc_src_jr_s  = 1'b1;
            instr_done_s = 1'b1;
            state_next_s = ST_FETCH;
          end
          CLS_RTYPE: state_next_s = ST_WB;
          CLS_ADDI, CLS_SUBI, CLS_SLTI, CLS_ANDI, CLS_ORI: begin
            alu_src_imm_s = 1'b1;
            state_next_s  = ST_WB;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_src_imm_s = 1'b1;
            state_next_s  = ST_MEM;
          end
          CLS_BEQ: begin
            pc_write_cond_s = zero;
            instr_done_s    = 1'b1;
            state_next_s    = ST_FETCH;
          end
          CLS_BNE: begin
            pc_write_cond_s = !zero;
            instr_done_s    = 1'b1;
            state_next_s    = ST_FETCH;
          end
          default: state_next_s = ST_ERROR;
        endcase
      end
      ST_MEM: begin
        alu_op_s = class_aluop(cls_r);
        if (cls_r == CLS_LOAD || cls_r == CLS_STORE) begin
          mem_read_s  = (cls_r == CLS_LOAD);
          mem_write_s = (cls_r == CLS_STORE);
          byte_en_s   = byte_r;
          if (mem_ready) begin
            instr_done_s = (cls_r == CLS_STORE);
            state_next_s = (cls_r == CLS_LOAD) ? ST_WB : ST_FETCH;
          end else if (timeout_s) begin
            state_next_s = ST_ERROR;
          end else begin
            state_next_s = ST_MEM;
          end
        end else begin
          state_next_s = ST_ERROR;
        end
      end
      ST_WB: begin
        reg_write_s  = 1'b1;
        reg_dst_s    = (cls_r == CLS_RTYPE);
        mem_to_reg_s = (cls_r == CLS_LOAD);
        instr_done_s = 1'b1;
        state_next_s = ST_FETCH;
      end
      ST_ERROR: begin
        alu_op_s     = 3'b000;
        state_next_s = ST_ERROR;
      end
      default: begin
        alu_op_s     = 3'b000;
        state_next_s = ST_ERROR;
      end
    endcase
  end

  // Strobes are masked while reset is asserted so an in-flight write is dropped at once.
  assign pc_write      = pc_write_s      & ~reset;
  assign pc_write_cond = pc_write_cond_s & ~reset;
  assign pc_src_jr     = pc_src_jr_s     & ~reset;
  assign ir_write      = ir_write_s      & ~reset;
  assign mem_read      = mem_read_s      & ~reset;
  assign mem_write     = mem_write_s     & ~reset;
  assign byte_en       = byte_en_s       & ~reset;
  assign reg_write     = reg_write_s     & ~reset;
  assign reg_dst       = reg_dst_s       & ~reset;
  assign mem_to_reg    = mem_to_reg_s    & ~reset;
  assign alu_src_imm   = alu_src_imm_s   & ~reset;
  assign instr_done    = instr_done_s    & ~reset;
  assign ALUop         = alu_op_s;
  assign state         = state_r;
  assign error         = (state_r == ST_ERROR);

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: a per-instruction reference model predicts
// cycle counts and strobe activity; a negedge monitor accumulates and compares.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [5:0] opcode, function_code;
  logic [2:0] ALUop, state;
  logic       error, pc_write, pc_write_cond, pc_src_jr, ir_write, mem_read, mem_write;
  logic       byte_en, reg_write, reg_dst, mem_to_reg, alu_src_imm, instr_done;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .function_code(function_code),
    .zero(zero), .mem_ready(mem_ready), .ALUop(ALUop), .state(state), .error(error),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src_jr(pc_src_jr),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write), .byte_en(byte_en),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_imm(alu_src_imm), .instr_done(instr_done)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit is_err;
    int cycles, exec_alu;
    int n_memrd, n_memwr, n_byte, n_irw, n_pcw, n_pcwc, n_jr;
    int n_regw, n_regdst, n_m2r, n_imm, n_badalu;
  } rec_t;

  rec_t exp_q[$];
  rec_t acc;
  bit   in_err;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int strobe_count();
    return $countones({pc_write, pc_write_cond, pc_src_jr, ir_write, mem_read, mem_write,
                       byte_en, reg_write, reg_dst, mem_to_reg, alu_src_imm, instr_done});
  endfunction

  function automatic bit is_ls(input int op);
    return (op == 35 || op == 32 || op == 43 || op == 40);
  endfunction

  // Reference model: what one instruction should do, from the instruction-set rules.
  function automatic rec_t model(input int op, input int fn, input int z, input int fd, input int md);
    rec_t r;
    int   kind, alu;
    bit   byt;
    r = '{default: 0};
    if (fd >= 8) begin
      r.is_err = 1'b1;
      r.cycles = 8;
      return r;
    end
    r.n_irw   = 1;
    r.n_pcw   = 1;
    r.n_memrd = fd + 1;
    byt = 1'b0;
    // kind: 0 R, 1 jr, 2 imm, 3 load, 4 store, 5 beq, 6 bne, 7 illegal
    case (op)
      0:  begin kind = (fn == 8) ? 1 : 0; alu = 7; end
      8:  begin kind = 2; alu = 5; end
      9:  begin kind = 2; alu = 6; end
      10: begin kind = 2; alu = 4; end
      12: begin kind = 2; alu = 0; end
      13: begin kind = 2; alu = 1; end
      35: begin kind = 3; alu = 5; end
      32: begin kind = 3; alu = 5; byt = 1'b1; end
      43: begin kind = 4; alu = 5; end
      40: begin kind = 4; alu = 5; byt = 1'b1; end
      4:  begin kind = 5; alu = 6; end
      5:  begin kind = 6; alu = 6; end
      default: begin kind = 7; alu = 0; end
    endcase
    if (kind == 7) begin
      r.is_err = 1'b1;
      r.cycles = fd + 2;
      return r;
    end
    r.exec_alu = alu;
    case (kind)
      0: begin r.cycles = fd + 4; r.n_regw = 1; r.n_regdst = 1; end
      1: begin r.cycles = fd + 3; r.n_pcw = 2; r.n_jr = 1; end
      2: begin r.cycles = fd + 4; r.n_regw = 1; r.n_imm = 1; end
      5: begin r.cycles = fd + 3; r.n_pcwc = (z != 0) ? 1 : 0; end
      6: begin r.cycles = fd + 3; r.n_pcwc = (z == 0) ? 1 : 0; end
      default: begin
        r.n_imm = 1;
        if (md >= 8) begin
          r.is_err = 1'b1;
          r.cycles = fd + 3 + 8;
          return r;
        end
        r.n_byte = byt ? md + 1 : 0;
        if (kind == 3) begin
          r.n_memrd += md + 1;
          r.cycles = fd + 3 + md + 2;
          r.n_regw = 1;
          r.n_m2r  = 1;
        end else begin
          r.n_memwr = md + 1;
          r.cycles  = fd + 3 + md + 1;
        end
      end
    endcase
    return r;
  endfunction

  task automatic score(input bit got_err);
    rec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty actual=unexpected_event required=no_event");
      return;
    end
    e = exp_q.pop_front();
    chk("ends_in_error", int'(got_err), int'(e.is_err));
    chk("cycles", acc.cycles, e.cycles);
    if (!got_err && !e.is_err) begin
      chk("exec_aluop", acc.exec_alu, e.exec_alu);
      chk("mem_read_cycles", acc.n_memrd, e.n_memrd);
      chk("mem_write_cycles", acc.n_memwr, e.n_memwr);
      chk("byte_en_cycles", acc.n_byte, e.n_byte);
      chk("ir_write_cycles", acc.n_irw, e.n_irw);
      chk("pc_write_cycles", acc.n_pcw, e.n_pcw);
      chk("pc_write_cond", acc.n_pcwc, e.n_pcwc);
      chk("pc_src_jr", acc.n_jr, e.n_jr);
      chk("reg_write", acc.n_regw, e.n_regw);
      chk("reg_dst", acc.n_regdst, e.n_regdst);
      chk("mem_to_reg", acc.n_m2r, e.n_m2r);
      chk("alu_src_imm", acc.n_imm, e.n_imm);
      chk("aluop_outside_exec", acc.n_badalu, e.n_badalu);
    end
  endtask

  // Monitor: accumulate per-instruction activity; score on instr_done or entry to ERROR.
  always @(negedge clk) begin
    if (reset) begin
      acc    = '{default: 0};
      in_err = 1'b0;
    end else if (!in_err) begin
      if (state == 3'd7) begin
        score(1'b1);
        in_err = 1'b1;
        acc    = '{default: 0};
      end else begin
        acc.cycles++;
        acc.n_memrd  += int'(mem_read);
        acc.n_memwr  += int'(mem_write);
        acc.n_byte   += int'(byte_en);
        acc.n_irw    += int'(ir_write);
        acc.n_pcw    += int'(pc_write);
        acc.n_pcwc   += int'(pc_write_cond);
        acc.n_jr     += int'(pc_src_jr);
        acc.n_regw   += int'(reg_write);
        acc.n_regdst += int'(reg_dst);
        acc.n_m2r    += int'(mem_to_reg);
        acc.n_imm    += int'(alu_src_imm);
        if (state == 3'd2) acc.exec_alu = int'(ALUop);
        else if (ALUop != 3'b101) acc.n_badalu++;
        if (instr_done) begin
          score(1'b0);
          acc = '{default: 0};
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    mem_ready = 1'b0;
    #1;
    chk("strobes_in_reset_cycle", strobe_count(), 0);
    @(posedge clk);
    #1;
    chk("state_after_reset", int'(state), 0);
    chk("error_after_reset", int'(error), 0);
    reset = 1'b0;
    #1;
    chk("first_fetch_mem_read", int'(mem_read), 1);
  endtask

  // Drive one instruction with fetch delay fd and memory delay md cycles.
  task automatic issue(input int op, input int fn, input int z, input int fd, input int md);
    rec_t r;
    r = model(op, fn, z, fd, md);
    exp_q.push_back(r);
    opcode        = 6'(op);
    function_code = 6'(fn);
    zero          = 1'(z);
    for (int k = 0; k < r.cycles; k++) begin
      mem_ready = ((k == fd) && fd < 8) || (is_ls(op) && k == fd + 3 + md && md < 8);
      step();
    end
    mem_ready = 1'b0;
    if (r.is_err) begin
      for (int h = 0; h < 3; h++) begin
        chk("error_held", int'(error), 1);
        chk("error_state", int'(state), 7);
        chk("error_aluop", int'(ALUop), 0);
        chk("error_strobes", strobe_count(), 0);
        step();
      end
      do_reset();
    end
  endtask

  function automatic bit is_legal(input int op);
    return (op == 0 || op == 8 || op == 9 || op == 10 || op == 12 || op == 13 || op == 4 ||
            op == 5 || is_ls(op));
  endfunction

  function automatic int pick_delay();
    int r;
    r = int'($urandom_range(0, 15));
    if (r < 13) return r % 5;
    else if (r < 15) return 7;
    else return 8;
  endfunction

  initial begin
    int ops[12] = '{0, 8, 9, 10, 12, 13, 35, 32, 43, 40, 4, 5};
    int op, fn;
    opcode = 6'd0; function_code = 6'd0; zero = 1'b0; mem_ready = 1'b0; reset = 1'b1;
    in_err = 1'b0;
    acc = '{default: 0};
    do_reset();

    issue(0, 2, 0, 0, 0);      // add
    issue(35, 0, 0, 0, 3);     // lw, memory late by 3
    issue(4, 0, 1, 0, 0);      // beq taken
    issue(5, 0, 1, 0, 0);      // bne not taken
    issue(63, 0, 0, 0, 0);     // illegal opcode
    issue(8, 0, 0, 8, 0);      // fetch timeout
    issue(8, 0, 0, 7, 0);      // fetch accepted on last cycle
    issue(0, 8, 0, 1, 0);      // jr
    issue(32, 0, 0, 0, 7);     // lb accepted on last cycle
    issue(43, 0, 0, 2, 8);     // sw memory timeout
    issue(40, 0, 0, 0, 1);     // sb

    // sb interrupted by reset while waiting in MEM
    opcode = 6'd40; function_code = 6'd0; zero = 1'b0;
    mem_ready = 1'b1; step();
    mem_ready = 1'b0; step(); step();
    chk("sb_mem_state", int'(state), 3);
    chk("sb_mem_write", int'(mem_write), 1);
    chk("sb_byte_en", int'(byte_en), 1);
    step();
    do_reset();

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = int'($urandom_range(0, 63)); while (is_legal(op));
      end else begin
        op = ops[$urandom_range(0, 11)];
      end
      fn = ($urandom_range(0, 3) == 0) ? 8 : int'($urandom_range(0, 63));
      issue(op, fn, int'($urandom_range(0, 1)), pick_delay(), pick_delay());
    end

    step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 8: maximum number of cycles to wait for mem_ready in FETCH or MEM before entering ERROR.
REQ-002 SHALL have clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have reset, input, 1: synchronous, active-high.
REQ-004 SHALL have opcode, input, 6: instruction bits [31:26] from the instruction register, sampled in DECODE.
REQ-005 SHALL have function_code, input, 6: instruction bits [5:0], sampled in DECODE.
REQ-006 SHALL have zero, input, 1: ALU zero flag, valid in EXEC.
REQ-007 SHALL have mem_ready, input, 1: memory access complete this cycle.
REQ-008 SHALL have the following state outputs: ALUop (output, 3, to alu_control), state (output, 3, current FSM state), and error (output, 1, sticky fault).
REQ-009 SHALL have the following datapath strobes, each output and 1 bit: pc_write, pc_write_cond, pc_src_jr, ir_write, mem_read, mem_write, byte_en, reg_write, reg_dst, mem_to_reg, alu_src_imm, and instr_done.

Function
REQ-010 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERROR=7, encoded on the state output.
REQ-011 SHALL decode these opcodes:
- R-type=000000
- addi=001000, subi=001001, slti=001010, andi=001100, ori=001101
- lw=100011, lb=100000, sw=101011, sb=101000
- beq=000100, bne=000101
Any other opcode is illegal.
REQ-012 SHALL latch the instruction class and the byte flag in DECODE; later states use only the latched values.
REQ-013 SHALL drive ALUop=101 in FETCH, DECODE and WB.
REQ-014 SHALL drive ALUop in EXEC and MEM according to the latched class:
- R-type: 111
- subi, beq, bne: 110
- addi and all loads/stores: 101
- slti: 100
- ori: 001
- andi: 000
REQ-015 FETCH SHALL assert mem_read every cycle.
REQ-016 In the FETCH cycle where mem_ready=1, the block SHALL assert ir_write and pc_write for that one cycle and move to DECODE.
REQ-017 DECODE SHALL last exactly one cycle and go to EXEC, or to ERROR on an illegal opcode.
REQ-018 EXEC SHALL last one cycle and assert alu_src_imm for every non-R, non-branch class.
REQ-019 EXEC SHALL transition on the latched class as follows:
- R-type with function_code=001000 (jr): assert pc_write and pc_src_jr, then go to FETCH.
- Other R-type and immediate ALU instructions: go to WB.
- Load/store: go to MEM.
- beq: assert pc_write_cond when zero=1, then go to FETCH.
- bne: assert pc_write_cond when zero=0, then go to FETCH.
REQ-020 MEM SHALL assert mem_read for loads or mem_write for stores, with byte_en=1 for lb/sb, held until mem_ready.
REQ-021 On mem_ready in MEM, a store SHALL go to FETCH and a load SHALL go to WB.
REQ-022 WB SHALL last one cycle, assert reg_write, set reg_dst=1 for R-type and mem_to_reg=1 for loads, then go to FETCH.
REQ-023 instr_done SHALL pulse for exactly one cycle on every transition into FETCH from EXEC, MEM or WB.
REQ-024 A wait counter SHALL clear on entry to FETCH and MEM and increment on each cycle with mem_ready=0.
REQ-025 If the wait counter reaches MEM_TIMEOUT with mem_ready still 0, the block SHALL go to ERROR; mem_ready arriving on the cycle the counter reaches MEM_TIMEOUT-1 is still accepted.
REQ-026 ERROR SHALL be absorbing: error=1, all strobes 0, ALUop=000, left only by reset.
REQ-027 Unlisted R-type function codes SHALL still complete through WB; alu_control's default handles them.

Reset
REQ-028 Reset asserted on a rising edge SHALL force state=FETCH, wait counter=0, error=0, latched class cleared, and all strobes 0 during the reset cycle.
REQ-029 Reset SHALL take priority over every transition, including mid-MEM writes and ERROR.
REQ-030 The first FETCH mem_read SHALL assert in the cycle after reset deasserts.

Verification
REQ-031 add (opcode 000000, funct 000010) with mem_ready immediate -> states FETCH, DECODE, EXEC(ALUop=111), WB(reg_write=1, reg_dst=1), then instr_done; 4 cycles total.
REQ-032 lw (100011) with mem_ready delayed 3 cycles in MEM -> MEM holds mem_read=1 and ALUop=101 for 4 cycles, then WB with mem_to_reg=1.
REQ-033 beq with zero=1, then bne with zero=1 -> pc_write_cond=1 on the first, 0 on the second; both return to FETCH after 3 cycles.
REQ-034 opcode 111111 -> ERROR after DECODE with error=1 held indefinitely; reset returns to FETCH with error=0.
REQ-035 mem_ready held 0 in FETCH -> ERROR after exactly 8 cycles; mem_ready on the 8th cycle (count=7) -> DECODE instead.
REQ-036 Reset asserted during sb MEM -> mem_write and byte_en drop in the reset cycle; state=FETCH.
